// File: rtl/dff_delay_line.sv
// Multi-channel registered delay line with shared valid path, occupancy count and synchronous flush.
// HOLD_MODE=0 zero-fills idle slots; HOLD_MODE=1 freezes the whole line while en is low.
module dff_delay_line #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HOLD_MODE  = 0
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               en,
  input  logic                               flush,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     d,
  output logic [CHANNELS*DATA_WIDTH-1:0]     q,
  output logic                               q_valid,
  output logic [$clog2(DEPTH+1)-1:0]         fill_cnt,
  output logic                               full
);

  localparam int unsigned LW    = CHANNELS * DATA_WIDTH;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam bit          STALL = (HOLD_MODE != 0);

  logic [DEPTH-1:0][LW-1:0] r_s;
  logic [DEPTH-1:0]         r_v;
  logic [CW-1:0]            r_fill;

  logic                     w_adv;
  logic [LW-1:0]            w_s0;
  logic signed [1:0]        w_step;
  logic signed [CW+1:0]     w_fill_sum;

  // Free-running lines advance every edge; stalled lines only on en.
  assign w_adv  = !STALL || en;
  // Idle slots are forced to zero so undriven d never propagates.
  assign w_s0   = en ? d : '0;

  // Occupancy moves by one signed step: sample in minus sample out.
  assign w_step     = $signed({1'b0, en}) - $signed({1'b0, r_v[DEPTH-1]});
  assign w_fill_sum = $signed({2'b00, r_fill}) + (CW+2)'(w_step);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s    <= '0;
      r_v    <= '0;
      r_fill <= '0;
    end else if (flush) begin
      r_s    <= '0;
      r_v    <= '0;
      r_fill <= '0;
    end else if (w_adv) begin
      r_s[0] <= w_s0;
      r_v[0] <= en;
      for (int i = 1; i < DEPTH; i++) begin
        r_s[i] <= r_s[i-1];
        r_v[i] <= r_v[i-1];
      end
      r_fill <= w_fill_sum[CW-1:0];
    end
  end

  assign q        = r_s[DEPTH-1];
  assign q_valid  = r_v[DEPTH-1];
  assign fill_cnt = r_fill;
  assign full     = (r_fill == CW'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: ten configurations share one stimulus stream and are checked
// every cycle against a history-based model, plus literal directed expectations.
module tb_dff_delay_line;

  localparam int NI = 10;

  function automatic int dep_of(input int g);
    case (g)
      0: return 4;
      1: return 3;
      2, 3: return 1;
      4, 5: return 2;
      6, 7: return 7;
      default: return 64;
    endcase
  endfunction

  function automatic int hm_of(input int g);
    case (g)
      0, 2, 4, 6, 8: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int ch_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  localparam logic [15:0] GAP_D [10] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'hDEAD,
                                         16'hDEAD, 16'd5, 16'd6, 16'd7, 16'd8};
  localparam logic        GAP_E [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [15:0] GAP_Q [10] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd5};
  localparam logic        GAP_V [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam int          GAP_F [10] = '{1, 2, 3, 4, 3, 2, 2, 2, 3, 4};

  logic        clk = 1'b0;
  logic        rstn, en, flush;
  logic [31:0] d_in;

  logic [31:0] dq    [NI];
  logic        dv    [NI];
  logic [6:0]  dfc   [NI];
  logic        dfull [NI];

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned D  = dep_of(g);
    localparam int unsigned HM = hm_of(g);
    localparam int unsigned CH = ch_of(g);
    localparam int unsigned CW = $clog2(D + 1);
    logic [CH*16-1:0] w_q;
    logic [CW-1:0]    w_fc;
    logic             w_v, w_full;

    dff_delay_line #(
      .DATA_WIDTH(16), .CHANNELS(CH), .DEPTH(D), .HOLD_MODE(HM)
    ) u_dut (
      .clk(clk), .rstn(rstn), .en(en), .flush(flush), .d(d_in[CH*16-1:0]),
      .q(w_q), .q_valid(w_v), .fill_cnt(w_fc), .full(w_full)
    );

    assign dq[g]    = 32'(w_q);
    assign dv[g]    = w_v;
    assign dfc[g]   = 7'(w_fc);
    assign dfull[g] = w_full;
  end

  // Model: slots since the last clear (every edge) and accepted samples since the last clear.
  logic [32:0] hist_all [$];
  logic [31:0] hist_en  [$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn || flush) begin
      hist_all.delete();
      hist_en.delete();
    end else begin
      hist_all.push_back({en, d_in});
      if (hist_all.size() > 64) void'(hist_all.pop_front());
      if (en) begin
        hist_en.push_back(d_in);
        if (hist_en.size() > 64) void'(hist_en.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", nm, g, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int          dd, n, lo, ef;
    logic [31:0] eq;
    logic        ev;
    logic [32:0] e;
    if (chk_on) begin
      for (int g = 0; g < NI; g++) begin
        dd = dep_of(g);
        eq = '0;
        ev = 1'b0;
        ef = 0;
        if (hm_of(g) == 0) begin
          n  = hist_all.size();
          lo = (n >= dd) ? n - dd : 0;
          for (int k = lo; k < n; k++) ef += int'(hist_all[k][32]);
          if (n >= dd) begin
            e  = hist_all[n - dd];
            ev = e[32];
            eq = e[32] ? e[31:0] : 32'h0;
          end
        end else begin
          n  = hist_en.size();
          ef = (n < dd) ? n : dd;
          if (n >= dd) begin
            ev = 1'b1;
            eq = hist_en[n - dd];
          end
        end
        if (ch_of(g) == 1) eq = eq & 32'h0000_FFFF;
        chk("model_q", g, dq[g], eq);
        chk("model_q_valid", g, 32'(dv[g]), 32'(ev));
        chk("model_fill_cnt", g, 32'(dfc[g]), 32'(ef));
        chk("model_full", g, 32'(dfull[g]), 32'(ef == dd));
        chk("fill_le_depth", g, 32'(dfc[g] <= 7'(dd)), 32'd1);
      end
    end
  end

  task automatic step(input logic e, input logic f, input logic [31:0] dv_in);
    en    = e;
    flush = f;
    d_in  = dv_in;
    @(negedge clk);
  endtask

  initial begin
    rstn  = 1'b1;
    en    = 1'b0;
    flush = 1'b0;
    d_in  = '0;
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    chk_on = 1'b1;
    chk("reset_q", 0, dq[0], 32'h0);
    chk("reset_q_valid", 0, 32'(dv[0]), 32'h0);
    chk("reset_fill", 0, 32'(dfc[0]), 32'h0);
    chk("reset_full", 0, 32'(dfull[0]), 32'h0);

    // Mid-stream asynchronous reset with samples in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("async_rst_q", g, dq[g], 32'h0);
      chk("async_rst_q_valid", g, 32'(dv[g]), 32'h0);
      chk("async_rst_fill", g, 32'(dfc[g]), 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Impulse through the default 4-stage line.
    step(1'b1, 1'b0, 32'hABCD_1234);
    chk("imp_fill1", 0, 32'(dfc[0]), 32'd1);
    chk("imp_qv1", 0, 32'(dv[0]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h5A5A_5A5A);
      chk("imp_fill", 0, 32'(dfc[0]), 32'd1);
      chk("imp_qv_early", 0, 32'(dv[0]), 32'd0);
    end
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    chk("imp_q", 0, dq[0], 32'hABCD_1234);
    chk("imp_qv", 0, 32'(dv[0]), 32'd1);
    chk("imp_fill4", 0, 32'(dfc[0]), 32'd1);
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    chk("imp_q_after", 0, dq[0], 32'h0);
    chk("imp_qv_after", 0, 32'(dv[0]), 32'd0);
    chk("imp_fill_after", 0, 32'(dfc[0]), 32'd0);

    // Gap in a ramp, free-running mode.
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(GAP_E[i], 1'b0, {16'h8000 | GAP_D[i], GAP_D[i]});
      chk("gap_q", 0, 32'(dq[0][15:0]), 32'(GAP_Q[i]));
      chk("gap_qv", 0, 32'(dv[0]), 32'(GAP_V[i]));
      chk("gap_fill", 0, 32'(dfc[0]), 32'(GAP_F[i]));
      chk("gap_full", 0, 32'(dfull[0]), 32'(GAP_F[i] == 4));
    end

    // Stall on the 3-stage hold-mode line.
    step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'd10);
    step(1'b1, 1'b0, 32'd20);
    step(1'b1, 1'b0, 32'd30);
    chk("stall_q_load", 1, dq[1], 32'd10);
    chk("stall_qv_load", 1, 32'(dv[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, $urandom);
      chk("stall_q_hold", 1, dq[1], 32'd10);
      chk("stall_fill_hold", 1, 32'(dfc[1]), 32'd3);
    end
    step(1'b1, 1'b0, 32'd40);
    chk("stall_q_resume", 1, dq[1], 32'd20);
    chk("stall_fill_resume", 1, 32'(dfc[1]), 32'd3);

    // Flush wins over a simultaneous enable.
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h00FF_00FF);
    chk("flush_pre_full", 0, 32'(dfull[0]), 32'd1);
    chk("flush_pre_q", 0, dq[0], 32'h00FF_00FF);
    step(1'b1, 1'b1, 32'h7777_7777);
    chk("flush_fill", 0, 32'(dfc[0]), 32'd0);
    chk("flush_qv", 0, 32'(dv[0]), 32'd0);
    chk("flush_full", 0, 32'(dfull[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("flush_no_7777", 0, dq[0], 32'h0);
    end

    // Randomized traffic with occasional flushes and asynchronous resets.
    for (int i = 0; i < 10000; i++) begin
      if (i % 2500 == 1234) begin
        en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn = 1'b1;
      end
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 2), $urandom);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
